pong_state_keeper: RTL and testbench
====================================

Name: pong_state_keeper

Overview:
- Sequential owner of the pong game state: holds paddles, ball, velocities and scores in registers.
- Drives them into the combinational pong step logic and writes the step results back once per frame tick.
- Adds a frame-rate divider, a serve delay after each point, game-over detection and a bounce counter.
- Sits between the player control inputs and the step logic. Display logic consumes its registered state.

Parameters:
- TICK_DIV, 4: clock cycles per game frame (min 1).
- SERVE_FRAMES, 8: frames the ball is held at centre before play. A value of 0 is treated as 1.
- WIN_SCORE, 9: score that ends the game (1..15).
- INIT_VEL_X, 1: serve x-velocity magnitude (signed 4-bit, positive).
- INIT_VEL_Y, 1: serve y-velocity (signed 4-bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin/restart game (level, sampled each edge)
- ctrl_1, ctrl_2  in  2 signed  raw player controls (-1/0/+1)
- st_control_1, st_control_2  out  2 signed  registered controls to step logic
- st_paddle_1_pos, st_paddle_2_pos  out  8 signed  paddle state
- st_ball_pos_x, st_ball_pos_y  out  8 signed  ball position state
- st_ball_vel_x, st_ball_vel_y  out  4 signed  ball velocity state
- st_score_p1, st_score_p2  out  4  scores
- step_paddle_1_pos, step_paddle_2_pos, step_ball_pos_x, step_ball_pos_y  in  8 signed  next state from step logic
- step_ball_vel_x, step_ball_vel_y  in  4 signed  next velocities
- step_score_p1, step_score_p2  in  4  next scores
- step_bounce  in  1  step logic bounce flag
- frame_tick  out  1  one-cycle frame strobe
- playing  out  1  state == PLAY
- game_over  out  1  state == OVER
- winner  out  1  0 = p1, 1 = p2; valid while game_over
- bounce_count  out  8  bounces this game, saturating at 255

Behaviour:
- Reset (reset==0 at a clk edge; wins over every other event):
  - state IDLE, tick_cnt 0, serve_cnt 0.
  - All positions 0; st_ball_vel_x = INIT_VEL_X, st_ball_vel_y = INIT_VEL_Y.
  - Scores 0, st_control 0, winner 0, bounce_count 0.
- Divider:
  - tick_cnt counts 0..TICK_DIV-1 and wraps; it runs in every state.
  - frame_tick = (tick_cnt == TICK_DIV-1), combinational from the register. First assertion is in cycle TICK_DIV-1 after reset release.
  - Frame updates occur on the edge where frame_tick is 1.
- Controls: st_control_n <= ctrl_n every edge in SERVE and PLAY; forced to 0 in IDLE and OVER.
- IDLE:
  - All state held.
  - On start=1: go to SERVE, serve_cnt <= max(SERVE_FRAMES, 1), scores <= 0, bounce_count <= 0.
- SERVE:
  - Ball position forced to (0,0).
  - On frame_tick: paddles <= step paddles, serve_cnt decrements. If serve_cnt was 1, go to PLAY.
  - start is ignored.
- PLAY:
  - On frame_tick, all st_* <= step_* (paddles, ball position, velocities, scores).
  - A gutter is step_score_p1 != st_score_p1 or step_score_p2 != st_score_p2.
  - Gutter, new score == WIN_SCORE (p1 checked first): go to OVER, winner <= 0 for p1 or 1 for p2, ball (0,0).
  - Gutter otherwise: go to SERVE, serve_cnt reloaded, ball (0,0), st_ball_vel_y <= INIT_VEL_Y.
    - st_ball_vel_x <= +INIT_VEL_X if p1 scored, -INIT_VEL_X if p2 scored.
    - The serve goes toward the player who conceded. If both scored, p1 rule applies.
  - step_bounce=1 with no gutter: bounce_count +1, saturating at 255.
  - Between ticks, no state changes. start is ignored.
- OVER:
  - All state held; game_over=1.
  - start=1 behaves exactly as in IDLE.
- Scores cannot wrap: OVER is entered at WIN_SCORE ≤ 15.
- Reset asserted mid-game, even coincident with frame_tick or a gutter: next state is IDLE with reset values.

Test Plan (TICK_DIV=4, SERVE_FRAMES=2, WIN_SCORE=3, INIT_VEL 1/1):
1. Hold reset low 3 cycles, release, start=0 → IDLE; all st_* = 0 except vel (1,1); frame_tick high every 4th cycle.
2. Pulse start, drive step_ball_pos_x=9 → SERVE; st_ball_pos stays (0,0); playing=1 right after the 2nd subsequent frame_tick.
3. In PLAY, step_ball_pos_x=5, step_ball_vel_x=-1 → st_ball_pos_x=5 and st_ball_vel_x=-1 only after a frame_tick edge, unchanged at non-tick edges.
4. In PLAY, step_score_p1=1 vs st 0 → SERVE, st_score_p1=1, ball (0,0), st_ball_vel_x=+1. Then step_score_p2=1 → st_ball_vel_x=-1.
5. Three step_bounce=1 ticks, then p2 reaches 3 → bounce_count=3, game_over=1, winner=1. Next start → scores 0, bounce_count 0, SERVE.
6. Reset low on the same edge as a frame_tick gutter → IDLE, scores 0, no OVER/SERVE transition taken.

Source files
------------

// File: rtl/pong_state_keeper.sv
// Registered owner of the pong game state: frame divider, serve delay,
// scoring/game-over sequencing and bounce counting around the step logic.
module pong_state_keeper #(
  parameter int                 TICK_DIV     = 4,
  parameter int                 SERVE_FRAMES = 8,
  parameter int                 WIN_SCORE    = 9,
  parameter logic signed [3:0]  INIT_VEL_X   = 4'sd1,
  parameter logic signed [3:0]  INIT_VEL_Y   = 4'sd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic signed [1:0] ctrl_1,
  input  logic signed [1:0] ctrl_2,
  output logic signed [1:0] st_control_1,
  output logic signed [1:0] st_control_2,
  output logic signed [7:0] st_paddle_1_pos,
  output logic signed [7:0] st_paddle_2_pos,
  output logic signed [7:0] st_ball_pos_x,
  output logic signed [7:0] st_ball_pos_y,
  output logic signed [3:0] st_ball_vel_x,
  output logic signed [3:0] st_ball_vel_y,
  output logic        [3:0] st_score_p1,
  output logic        [3:0] st_score_p2,
  input  logic signed [7:0] step_paddle_1_pos,
  input  logic signed [7:0] step_paddle_2_pos,
  input  logic signed [7:0] step_ball_pos_x,
  input  logic signed [7:0] step_ball_pos_y,
  input  logic signed [3:0] step_ball_vel_x,
  input  logic signed [3:0] step_ball_vel_y,
  input  logic        [3:0] step_score_p1,
  input  logic        [3:0] step_score_p2,
  input  logic              step_bounce,
  output logic              frame_tick,
  output logic              playing,
  output logic              game_over,
  output logic              winner,
  output logic        [7:0] bounce_count
);

  localparam int TICK_MAX   = (TICK_DIV < 1) ? 0 : TICK_DIV - 1;
  localparam int TICK_W     = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
  localparam int SERVE_LOAD = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
  localparam int SERVE_W    = $clog2(SERVE_LOAD + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_MAX);
  localparam logic [SERVE_W-1:0] SERVE_INIT = SERVE_W'(SERVE_LOAD);
  localparam logic [SERVE_W-1:0] SERVE_ONE  = SERVE_W'(1);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
  localparam logic signed [3:0]  NEG_VEL_X  = -INIT_VEL_X;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [TICK_W-1:0]    tick_cnt_reg;
  logic [SERVE_W-1:0]   serve_cnt_reg;

  logic gutter_p1;
  logic gutter_p2;
  logic gutter;
  logic win_p1;
  logic win_p2;

  assign frame_tick = (tick_cnt_reg == TICK_LAST);
  assign playing    = (state_reg == PLAY);
  assign game_over  = (state_reg == OVER);

  assign gutter_p1 = (step_score_p1 != st_score_p1);
  assign gutter_p2 = (step_score_p2 != st_score_p2);
  assign gutter    = gutter_p1 | gutter_p2;
  // p1 has priority when both reach the winning score on one frame
  assign win_p1    = gutter && (step_score_p1 == WIN);
  assign win_p2    = gutter && (step_score_p2 == WIN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      tick_cnt_reg    <= '0;
      serve_cnt_reg   <= '0;
      st_control_1    <= '0;
      st_control_2    <= '0;
      st_paddle_1_pos <= '0;
      st_paddle_2_pos <= '0;
      st_ball_pos_x   <= '0;
      st_ball_pos_y   <= '0;
      st_ball_vel_x   <= INIT_VEL_X;
      st_ball_vel_y   <= INIT_VEL_Y;
      st_score_p1     <= '0;
      st_score_p2     <= '0;
      winner          <= 1'b0;
      bounce_count    <= '0;
    end else begin
      tick_cnt_reg <= frame_tick ? '0 : tick_cnt_reg + 1'b1;

      case (state_reg)
        IDLE, OVER: begin
          st_control_1 <= '0;
          st_control_2 <= '0;
          if (start) begin
            state_reg     <= SERVE;
            serve_cnt_reg <= SERVE_INIT;
            st_score_p1   <= '0;
            st_score_p2   <= '0;
            bounce_count  <= '0;
          end
        end

        SERVE: begin
          st_control_1  <= ctrl_1;
          st_control_2  <= ctrl_2;
          st_ball_pos_x <= '0;
          st_ball_pos_y <= '0;
          if (frame_tick) begin
            st_paddle_1_pos <= step_paddle_1_pos;
            st_paddle_2_pos <= step_paddle_2_pos;
            serve_cnt_reg   <= serve_cnt_reg - 1'b1;
            if (serve_cnt_reg == SERVE_ONE)
              state_reg <= PLAY;
          end
        end

        PLAY: begin
          st_control_1 <= ctrl_1;
          st_control_2 <= ctrl_2;
          if (frame_tick) begin
            st_paddle_1_pos <= step_paddle_1_pos;
            st_paddle_2_pos <= step_paddle_2_pos;
            st_ball_pos_x   <= step_ball_pos_x;
            st_ball_pos_y   <= step_ball_pos_y;
            st_ball_vel_x   <= step_ball_vel_x;
            st_ball_vel_y   <= step_ball_vel_y;
            st_score_p1     <= step_score_p1;
            st_score_p2     <= step_score_p2;
            if (win_p1 || win_p2) begin
              state_reg     <= OVER;
              winner        <= !win_p1;
              st_ball_pos_x <= '0;
              st_ball_pos_y <= '0;
            end else if (gutter) begin
              // serve heads toward whoever conceded the point
              state_reg     <= SERVE;
              serve_cnt_reg <= SERVE_INIT;
              st_ball_pos_x <= '0;
              st_ball_pos_y <= '0;
              st_ball_vel_x <= gutter_p1 ? INIT_VEL_X : NEG_VEL_X;
              st_ball_vel_y <= INIT_VEL_Y;
            end else if (step_bounce && (bounce_count != 8'hFF)) begin
              bounce_count <= bounce_count + 8'd1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_state_keeper.sv
// Directed bench for pong_state_keeper: reset, divider, serve, play updates,
// scoring, game over, restart and reset during a gutter frame.
module tb_pong_state_keeper;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic signed [1:0] ctrl_1, ctrl_2;
  logic signed [1:0] st_control_1, st_control_2;
  logic signed [7:0] st_paddle_1_pos, st_paddle_2_pos, st_ball_pos_x, st_ball_pos_y;
  logic signed [3:0] st_ball_vel_x, st_ball_vel_y;
  logic        [3:0] st_score_p1, st_score_p2;
  logic signed [7:0] step_paddle_1_pos, step_paddle_2_pos, step_ball_pos_x, step_ball_pos_y;
  logic signed [3:0] step_ball_vel_x, step_ball_vel_y;
  logic        [3:0] step_score_p1, step_score_p2;
  logic              step_bounce;
  logic              frame_tick, playing, game_over, winner;
  logic        [7:0] bounce_count;

  int checks = 0;
  int failures = 0;
  int tcnt = 0;

  pong_state_keeper #(
    .TICK_DIV(4), .SERVE_FRAMES(2), .WIN_SCORE(3),
    .INIT_VEL_X(4'sd1), .INIT_VEL_Y(4'sd1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ctrl_1(ctrl_1), .ctrl_2(ctrl_2),
    .st_control_1(st_control_1), .st_control_2(st_control_2),
    .st_paddle_1_pos(st_paddle_1_pos), .st_paddle_2_pos(st_paddle_2_pos),
    .st_ball_pos_x(st_ball_pos_x), .st_ball_pos_y(st_ball_pos_y),
    .st_ball_vel_x(st_ball_vel_x), .st_ball_vel_y(st_ball_vel_y),
    .st_score_p1(st_score_p1), .st_score_p2(st_score_p2),
    .step_paddle_1_pos(step_paddle_1_pos), .step_paddle_2_pos(step_paddle_2_pos),
    .step_ball_pos_x(step_ball_pos_x), .step_ball_pos_y(step_ball_pos_y),
    .step_ball_vel_x(step_ball_vel_x), .step_ball_vel_y(step_ball_vel_y),
    .step_score_p1(step_score_p1), .step_score_p2(step_score_p2),
    .step_bounce(step_bounce),
    .frame_tick(frame_tick), .playing(playing), .game_over(game_over),
    .winner(winner), .bounce_count(bounce_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; tcnt models the expected frame divider.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = reset;
    @(posedge clk);
    #1;
    tcnt = (rst_at_edge == 1'b0) ? 0 : (tcnt + 1) % 4;
  endtask

  // Advance until the next edge is a frame edge, checking the strobe.
  task automatic to_tick();
    while (tcnt != 3) tick();
    chk("frame_tick_pre", frame_tick, 1);
  endtask

  task automatic frame();
    to_tick();
    tick();
  endtask

  task automatic show(input string what);
    $display("t=%0t %s: play=%0d over=%0d ball=(%0d,%0d) vel=(%0d,%0d) score=%0d:%0d bounces=%0d",
             $time, what, playing, game_over, st_ball_pos_x, st_ball_pos_y,
             st_ball_vel_x, st_ball_vel_y, st_score_p1, st_score_p2, bounce_count);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ctrl_1 = 2'sd1; ctrl_2 = -2'sd1;
    step_paddle_1_pos = 8'sd0; step_paddle_2_pos = 8'sd0;
    step_ball_pos_x = 8'sd0; step_ball_pos_y = 8'sd0;
    step_ball_vel_x = 4'sd1; step_ball_vel_y = 4'sd1;
    step_score_p1 = 4'd0; step_score_p2 = 4'd0; step_bounce = 1'b0;

    // 1: reset and IDLE, divider cadence
    repeat (3) tick();
    reset = 1'b1;
    show("after reset");
    chk("rst_playing", playing, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_paddle1", st_paddle_1_pos, 0);
    chk("rst_ball_x", st_ball_pos_x, 0);
    chk("rst_vel_x", st_ball_vel_x, 1);
    chk("rst_vel_y", st_ball_vel_y, 1);
    chk("rst_score_p1", st_score_p1, 0);
    chk("rst_bounce", bounce_count, 0);
    chk("rst_winner", winner, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_frame_tick", frame_tick, (tcnt == 3) ? 1 : 0);
    end
    chk("idle_ctrl_forced0", st_control_1, 0);
    chk("idle_playing", playing, 0);

    // 2: start -> SERVE, ball held at centre, PLAY after two frames
    start = 1'b1; step_ball_pos_x = 8'sd9; step_paddle_1_pos = 8'sd4;
    tick();
    start = 1'b0;
    show("serve");
    chk("serve_ball_x", st_ball_pos_x, 0);
    chk("serve_playing", playing, 0);
    tick();
    chk("serve_ctrl1", st_control_1, 1);
    chk("serve_ctrl2", st_control_2, -1);
    frame();
    chk("serve_paddle1", st_paddle_1_pos, 4);
    chk("serve_f1_playing", playing, 0);
    chk("serve_f1_ball_x", st_ball_pos_x, 0);
    frame();
    show("play");
    chk("serve_f2_playing", playing, 1);
    chk("serve_f2_ball_x", st_ball_pos_x, 0);

    // 3: PLAY updates only on frame edges
    step_ball_pos_x = 8'sd5; step_ball_vel_x = -4'sd1;
    tick();
    chk("play_nontick_ball_x", st_ball_pos_x, 0);
    chk("play_nontick_vel_x", st_ball_vel_x, 1);
    frame();
    show("play frame");
    chk("play_tick_ball_x", st_ball_pos_x, 5);
    chk("play_tick_vel_x", st_ball_vel_x, -1);
    chk("play_tick_score_p1", st_score_p1, 0);

    // 4: p1 scores -> SERVE toward p2 (+x); then p2 scores -> -x
    step_score_p1 = 4'd1; step_ball_pos_x = 8'sd7; step_ball_pos_y = 8'sd3;
    step_ball_vel_y = 4'sd2;
    frame();
    show("p1 point");
    chk("p1pt_playing", playing, 0);
    chk("p1pt_score_p1", st_score_p1, 1);
    chk("p1pt_ball_x", st_ball_pos_x, 0);
    chk("p1pt_ball_y", st_ball_pos_y, 0);
    chk("p1pt_vel_x", st_ball_vel_x, 1);
    chk("p1pt_vel_y", st_ball_vel_y, 1);
    frame();
    frame();
    chk("p1pt_back_playing", playing, 1);
    step_score_p2 = 4'd1;
    frame();
    show("p2 point");
    chk("p2pt_score_p2", st_score_p2, 1);
    chk("p2pt_vel_x", st_ball_vel_x, -1);
    chk("p2pt_playing", playing, 0);
    frame();
    frame();
    chk("p2pt_back_playing", playing, 1);

    // 5: three bounces, p2 to 3 -> OVER, then restart
    step_bounce = 1'b1;
    frame(); frame(); frame();
    step_bounce = 1'b0;
    chk("bounce_three", bounce_count, 3);
    step_score_p2 = 4'd2;
    frame();
    chk("p2_two_serve", playing, 0);
    chk("p2_two_over", game_over, 0);
    frame();
    frame();
    step_score_p2 = 4'd3;
    frame();
    show("game over");
    chk("over_game_over", game_over, 1);
    chk("over_winner", winner, 1);
    chk("over_score_p2", st_score_p2, 3);
    chk("over_bounce", bounce_count, 3);
    chk("over_ball_x", st_ball_pos_x, 0);
    tick();
    chk("over_ctrl_forced0", st_control_1, 0);
    chk("over_hold", game_over, 1);
    step_score_p1 = 4'd0; step_score_p2 = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    show("restart");
    chk("restart_score_p1", st_score_p1, 0);
    chk("restart_score_p2", st_score_p2, 0);
    chk("restart_bounce", bounce_count, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_playing", playing, 0);
    frame();
    frame();
    chk("restart_playing_after", playing, 1);

    // 6: reset coincident with a gutter frame
    step_score_p1 = 4'd1;
    to_tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    show("reset on gutter");
    chk("rstg_playing", playing, 0);
    chk("rstg_game_over", game_over, 0);
    chk("rstg_score_p1", st_score_p1, 0);
    chk("rstg_vel_x", st_ball_vel_x, 1);
    chk("rstg_frame_tick", frame_tick, 0);
    tick();
    chk("rstg_idle_hold", playing, 0);
    chk("rstg_idle_score", st_score_p1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
